// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared opcode/class encodings, reset polarity and divider states for the execute stage
package ex_mdu_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ZERO,
        DIV_ON,
        DIV_END
    } div_state_e;

endpackage

// File: rtl/ex_mdu_div_iter.sv
// div_iter: iterative radix-2 restoring divider with signed fixup, stall request and flush abort
module div_iter import ex_mdu_pkg::*; #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic              annul_i,
    input  logic [WIDTH-1:0]  dividend_i,
    input  logic [WIDTH-1:0]  divisor_i,
    input  logic [ADDR_W-1:0] tag_i,
    output logic              stall_o,
    output logic              ready_o,
    output logic [WIDTH-1:0]  quo_o,
    output logic [WIDTH-1:0]  rem_o,
    output logic [ADDR_W-1:0] tag_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              neg1, neg2;
    logic [WIDTH-1:0]  mag1, mag2;
    logic [WIDTH:0]    partial, diff;

    assign neg1    = signed_i & dividend_i[WIDTH-1];
    assign neg2    = signed_i & divisor_i[WIDTH-1];
    assign mag1    = neg1 ? -dividend_i : dividend_i;
    assign mag2    = neg2 ? -divisor_i : divisor_i;
    // Quotient register doubles as the dividend shift register; its MSB feeds the partial remainder.
    assign partial = {rem_q, quo_q[WIDTH-1]};
    assign diff    = partial - {1'b0, dvs_q};

    // Next state and one restoring-subtract step per DIV_ON cycle; a flush always wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        tag_d   = tag_q;
        case (state_q)
            DIV_IDLE: if (start_i) begin
                tag_d = tag_i;
                cnt_d = '0;
                rem_d = '0;
                if (divisor_i == '0) begin
                    state_d = DIV_ZERO;
                    quo_d   = '0;
                    dvs_d   = '0;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                end else begin
                    state_d = DIV_ON;
                    quo_d   = mag1;
                    dvs_d   = mag2;
                    qneg_d  = neg1 ^ neg2;
                    rneg_d  = neg1;
                end
            end
            DIV_ZERO: state_d = DIV_END;
            DIV_ON: begin
                rem_d   = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? DIV_END : DIV_ON;
            end
            default: state_d = DIV_IDLE;
        endcase
        if (annul_i) state_d = DIV_IDLE;
    end

    // Divider state and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            tag_q   <= tag_d;
        end
    end

    assign stall_o = (rst != RstEnable) && !annul_i &&
                     ((state_q == DIV_IDLE && start_i) || state_q == DIV_ZERO || state_q == DIV_ON);
    assign ready_o = state_q == DIV_END;
    assign quo_o   = qneg_q ? -quo_q : quo_q;
    assign rem_o   = rneg_q ? -rem_q : rem_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: registered execute stage with ALU, multiplier and iterative divider driving GPR and HI/LO write-back
module ex_mdu import ex_mdu_pkg::*; #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [WIDTH-1:0]  reg1_i,
    input  logic [WIDTH-1:0]  reg2_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic              annul_i,
    output logic              stallreq_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [WIDTH-1:0]  wdata_o,
    output logic              whilo_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic [WIDTH-1:0]  lo_o
);

    logic                 div_op, mul_op, mul_signed;
    logic                 div_ready;
    logic [WIDTH-1:0]     div_quo, div_rem;
    logic [ADDR_W-1:0]    div_wd;
    logic [SHAMT_W-1:0]   shamt;
    logic [WIDTH-1:0]     sra_res, logic_res, shift_res, arith_res, alu_res;
    logic                 slt_res;
    logic [2*WIDTH-1:0]   prod;
    logic                 valid_d, wreg_d, whilo_d;
    logic [ADDR_W-1:0]    wd_d;
    logic [WIDTH-1:0]     wdata_d, hi_d, lo_d;

    assign div_op     = aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP;
    assign mul_op     = aluop_i == EXE_MULT_OP || aluop_i == EXE_MULTU_OP;
    assign mul_signed = aluop_i == EXE_MULT_OP;
    assign shamt      = reg1_i[SHAMT_W-1:0];
    // Kept as standalone assignments so the signed operators are not coerced unsigned by a mixed ?: chain.
    assign sra_res    = $signed(reg2_i) >>> shamt;
    assign slt_res    = $signed(reg1_i) < $signed(reg2_i);
    assign prod       = {{WIDTH{mul_signed & reg1_i[WIDTH-1]}}, reg1_i} *
                        {{WIDTH{mul_signed & reg2_i[WIDTH-1]}}, reg2_i};

    div_iter #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (valid_i & div_op),
        .signed_i   (aluop_i == EXE_DIV_OP),
        .annul_i    (annul_i),
        .dividend_i (reg1_i),
        .divisor_i  (reg2_i),
        .tag_i      (wd_i),
        .stall_o    (stallreq_o),
        .ready_o    (div_ready),
        .quo_o      (div_quo),
        .rem_o      (div_rem),
        .tag_o      (div_wd)
    );

    // Per-class results; an opcode outside its class yields zero, and alusel picks the class.
    always_comb begin
        logic_res = aluop_i == EXE_OR_OP  ? reg1_i | reg2_i :
                    aluop_i == EXE_AND_OP ? reg1_i & reg2_i :
                    aluop_i == EXE_XOR_OP ? reg1_i ^ reg2_i :
                    aluop_i == EXE_NOR_OP ? ~(reg1_i | reg2_i) : '0;
        shift_res = aluop_i == EXE_SLL_OP ? reg2_i << shamt :
                    aluop_i == EXE_SRL_OP ? reg2_i >> shamt :
                    aluop_i == EXE_SRA_OP ? sra_res : '0;
        arith_res = (aluop_i == EXE_ADD_OP || aluop_i == EXE_ADDU_OP) ? reg1_i + reg2_i :
                    (aluop_i == EXE_SUB_OP || aluop_i == EXE_SUBU_OP) ? reg1_i - reg2_i :
                    aluop_i == EXE_SLT_OP  ? {{(WIDTH-1){1'b0}}, slt_res} :
                    aluop_i == EXE_SLTU_OP ? {{(WIDTH-1){1'b0}}, reg1_i < reg2_i} : '0;
        alu_res   = alusel_i == EXE_RES_LOGIC ? logic_res :
                    alusel_i == EXE_RES_SHIFT ? shift_res :
                    alusel_i == EXE_RES_ARITH ? arith_res : '0;
    end

    // Output mux: finished division first, then a single-cycle issue, otherwise a bubble.
    always_comb begin
        valid_d = 1'b0;
        wd_d    = '0;
        wreg_d  = 1'b0;
        wdata_d = '0;
        whilo_d = 1'b0;
        hi_d    = '0;
        lo_d    = '0;
        if (div_ready && !annul_i) begin
            valid_d = 1'b1;
            wd_d    = div_wd;
            whilo_d = 1'b1;
            hi_d    = div_rem;
            lo_d    = div_quo;
        end else if (valid_i && !annul_i && !div_op) begin
            valid_d = 1'b1;
            wd_d    = wd_i;
            wreg_d  = wreg_i & ~mul_op;
            wdata_d = alu_res;
            whilo_d = mul_op;
            hi_d    = mul_op ? prod[2*WIDTH-1:WIDTH] : '0;
            lo_d    = mul_op ? prod[WIDTH-1:0] : '0;
        end
    end

    // EX/MEM-facing output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            valid_o <= 1'b0;
            wd_o    <= '0;
            wreg_o  <= 1'b0;
            wdata_o <= '0;
            whilo_o <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            valid_o <= valid_d;
            wd_o    <= wd_d;
            wreg_o  <= wreg_d;
            wdata_o <= wdata_d;
            whilo_o <= whilo_d;
            hi_o    <= hi_d;
            lo_o    <= lo_d;
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed and randomized checks of ex_mdu against an arithmetic reference model
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        valid_i = 1'b0, wreg_i = 1'b0, annul_i = 1'b0;
    logic [7:0]  aluop_i = '0;
    logic [2:0]  alusel_i = '0;
    logic [31:0] reg1_i = '0, reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        stallreq_o, valid_o, wreg_o, whilo_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    int n_chk = 0, n_fail = 0;

    logic [7:0] ops [17] = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
                             EXE_SRA_OP, EXE_ADD_OP, EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP, EXE_SLT_OP,
                             EXE_SLTU_OP, EXE_MULT_OP, EXE_MULTU_OP, EXE_NOP_OP, 8'hFF};

    ex_mdu #(.WIDTH(32), .ADDR_W(5), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .annul_i(annul_i),
        .stallreq_o(stallreq_o), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".valid"}, 64'(valid_o), 64'(e.valid));
        check({tag, ".wd"},    64'(wd_o),    64'(e.wd));
        check({tag, ".wreg"},  64'(wreg_o),  64'(e.wreg));
        check({tag, ".wdata"}, 64'(wdata_o), 64'(e.wdata));
        check({tag, ".whilo"}, 64'(whilo_o), 64'(e.whilo));
        check({tag, ".hi"},    64'(hi_o),    64'(e.hi));
        check({tag, ".lo"},    64'(lo_o),    64'(e.lo));
    endtask

    // Result class each opcode belongs to; -1 for opcodes with no GPR result.
    function automatic int class_of(input logic [7:0] op);
        case (op)
            EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP:            return int'(EXE_RES_LOGIC);
            EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:                       return int'(EXE_RES_SHIFT);
            EXE_ADD_OP, EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP,
            EXE_SLT_OP, EXE_SLTU_OP:                                  return int'(EXE_RES_ARITH);
            default:                                                  return -1;
        endcase
    endfunction

    function automatic exp_t model(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] wd, input logic wr,
                                   input logic v, input logic an);
        exp_t e = '0;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        longint p;
        logic [31:0] r = '0;
        if (!v || an) return e;
        e.valid = 1'b1;
        e.wd    = wd;
        if (op == EXE_MULT_OP || op == EXE_MULTU_OP) begin
            p = (op == EXE_MULT_OP) ? sa * sb : ua * ub;
            e.whilo = 1'b1;
            e.hi    = p[63:32];
            e.lo    = p[31:0];
            return e;
        end
        e.wreg = wr;
        case (op)
            EXE_OR_OP:   r = a | b;
            EXE_AND_OP:  r = a & b;
            EXE_XOR_OP:  r = a ^ b;
            EXE_NOR_OP:  r = ~(a | b);
            EXE_SLL_OP:  r = b << a[4:0];
            EXE_SRL_OP:  r = b >> a[4:0];
            EXE_SRA_OP:  begin p = sb >>> a[4:0]; r = p[31:0]; end
            EXE_ADD_OP, EXE_ADDU_OP: begin p = ua + ub; r = p[31:0]; end
            EXE_SUB_OP, EXE_SUBU_OP: begin p = ua - ub; r = p[31:0]; end
            EXE_SLT_OP:  r = (sa < sb) ? 32'd1 : 32'd0;
            EXE_SLTU_OP: r = (ua < ub) ? 32'd1 : 32'd0;
            default:     r = '0;
        endcase
        e.wdata = (class_of(op) == int'(sel)) ? r : '0;
        return e;
    endfunction

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wr,
                         input logic v, input logic an);
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b;
        wd_i = wd; wreg_i = wr; valid_i = v; annul_i = an;
    endtask

    task automatic single(input string tag, input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                          input logic wr, input logic v, input logic an);
        drive(op, sel, a, b, wd, wr, v, an);
        @(negedge clk);
        check({tag, ".stall"}, 64'(stallreq_o), 64'd0);
        @(posedge clk); #1;
        check_out(tag, model(op, sel, a, b, wd, wr, v, an));
    endtask

    // Divide and check latency, stall-cycle count, bubbles while stalled and the HI/LO result.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] wd = 5'($urandom_range(1, 31));
        longint x = sgn ? longint'($signed(a)) : longint'({32'h0, a});
        longint y = sgn ? longint'($signed(b)) : longint'({32'h0, b});
        longint q = (b == 0) ? 0 : x / y;
        longint r = (b == 0) ? 0 : x % y;
        int edges = 0, stalls = 0, bad = 0;
        exp_t e = '0;
        drive(sgn ? EXE_DIV_OP : EXE_DIVU_OP, EXE_RES_NOP, a, b, wd, 1'b1, 1'b1, 1'b0);
        while (edges < 60) begin
            @(negedge clk);
            if (stallreq_o) stalls++;
            @(posedge clk); #1;
            edges++;
            if (valid_o) break;
            if (whilo_o || wreg_o) bad++;
        end
        drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check({tag, ".latency"}, 64'(edges), (b == 0) ? 64'd3 : 64'd34);
        check({tag, ".stalls"}, 64'(stalls), (b == 0) ? 64'd2 : 64'd33);
        check({tag, ".early_write"}, 64'(bad), 64'd0);
        e.valid = 1'b1; e.wd = wd; e.whilo = 1'b1; e.hi = r[31:0]; e.lo = q[31:0];
        check_out(tag, e);
    endtask

    // Watch a stretch of idle cycles for any stray HI/LO write or stall.
    task automatic quiet(input string tag, input int cycles);
        int hw = 0, st = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (stallreq_o) st++;
            if (whilo_o) hw++;
        end
        @(posedge clk); #1;
        check({tag, ".whilo_seen"}, 64'(hw), 64'd0);
        check({tag, ".stall_seen"}, 64'(st), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", '0);
        check("reset.stall", 64'(stallreq_o), 64'd0);
        rst = 1'b0;

        single("or",   EXE_OR_OP,   EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_00F0, 5'd3, 1'b1, 1'b1, 1'b0);
        single("sra",  EXE_SRA_OP,  EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd4, 1'b1, 1'b1, 1'b0);
        single("sltu", EXE_SLTU_OP, EXE_RES_ARITH, 32'd1, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b1, 1'b0);
        single("slt",  EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1, 1'b1, 1'b0);
        single("sub",  EXE_SUB_OP,  EXE_RES_ARITH, 32'd0, 32'd1, 5'd7, 1'b1, 1'b1, 1'b0);
        single("mult", EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8, 1'b1, 1'b1, 1'b0);
        single("bubble", EXE_OR_OP, EXE_RES_LOGIC, 32'h1, 32'h2, 5'd9, 1'b1, 1'b0, 1'b0);
        single("annul_idle", EXE_OR_OP, EXE_RES_LOGIC, 32'h1, 32'h2, 5'd9, 1'b1, 1'b1, 1'b1);
        single("badsel", EXE_ADD_OP, 3'b111, 32'h1, 32'h2, 5'd10, 1'b1, 1'b1, 1'b0);

        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_div("divu_zero", 1'b0, 32'd1234, 32'd0);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        single("after_div", EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_00F0, 5'd11, 1'b1, 1'b1, 1'b0);

        drive(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd12, 1'b1, 1'b1, 1'b0);
        repeat (11) @(posedge clk);
        #1 annul_i = 1'b1;
        #1 check("annul.stall", 64'(stallreq_o), 64'd0);
        @(posedge clk); #1;
        drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("annul.valid", 64'(valid_o), 64'd0);
        quiet("annul", 40);
        single("annul_or", EXE_OR_OP, EXE_RES_LOGIC, 32'h1234_0000, 32'h0000_5678, 5'd13, 1'b1, 1'b1, 1'b0);

        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd5000, 32'd9, 5'd14, 1'b1, 1'b1, 1'b0);
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid.stall", 64'(stallreq_o), 64'd0);
        check_out("rst_mid", '0);
        @(posedge clk); #1;
        drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        quiet("rst_mid", 40);
        single("rst_or", EXE_OR_OP, EXE_RES_LOGIC, 32'hA000_0000, 32'h0000_000B, 5'd15, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [7:0] op = ops[$urandom_range(0, 16)];
            int cls = class_of(op);
            logic [2:0] sel = ($urandom_range(0, 4) != 0 && cls >= 0) ? 3'(cls) : 3'($urandom_range(0, 7));
            single($sformatf("rnd%0d", i), op, sel, pick(), pick(), 5'($urandom), 1'($urandom),
                   1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0));
        end

        for (int i = 0; i < 12; i++) begin
            logic [31:0] b = ($urandom_range(0, 3) == 0) ? 32'h0 : pick();
            run_div($sformatf("rdiv%0d", i), 1'($urandom), pick(), b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
